// File: rtl/locked_mult_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : locked_mult_error_monitor
// Purpose  : Downstream observer for a key-locked 8x8 multiplier. Recomputes
//            the golden product for every operand pair in a programmed window
//            and counts mismatching results and the total flipped output bits.
// Ports    : clk_i, rst_i (sync, active-high)
//            start_i, num_vectors_i, keyinput_i : window control (IDLE only)
//            valid_i, operand1_i, operand2_i, result_i : observed triple
//            busy_o, done_o, key_o : status and latched key
//            vec_count_o, mismatch_count_o, bit_error_total_o : results
// Option   : `define LMEM_FIRST_FAIL_EN adds first_fail_* outputs capturing
//            the window index and data of the first mismatching vector.
// Revision : 1.0 - initial release
// ============================================================================
module locked_mult_error_monitor #(
    parameter int OP_W  = 8,
    parameter int RES_W = 16,
    parameter int KEY_W = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_vectors_i,
    input  logic [KEY_W-1:0] keyinput_i,
    input  logic             valid_i,
    input  logic [OP_W-1:0]  operand1_i,
    input  logic [OP_W-1:0]  operand2_i,
    input  logic [RES_W-1:0] result_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [KEY_W-1:0] key_o,
    output logic [CNT_W-1:0] vec_count_o,
    output logic [CNT_W-1:0] mismatch_count_o,
    output logic [CNT_W-1:0] bit_error_total_o
`ifdef LMEM_FIRST_FAIL_EN
    ,
    output logic             first_fail_valid_o,
    output logic [CNT_W-1:0] first_fail_idx_o,
    output logic [OP_W-1:0]  first_fail_op1_o,
    output logic [OP_W-1:0]  first_fail_op2_o,
    output logic [RES_W-1:0] first_fail_result_o
`endif
);

    // Popcount of a RES_W vector ranges 0..RES_W, so it needs one extra bit.
    localparam int c_PC_W  = $clog2(RES_W + 1);
    // Adder is wide enough for both operands plus carry, so a popcount wider
    // than a narrow counter still saturates correctly instead of truncating.
    localparam int c_ADD_W = ((CNT_W > c_PC_W) ? CNT_W : c_PC_W) + 1;
    localparam logic [c_ADD_W-1:0] c_CNT_MAX = c_ADD_W'({CNT_W{1'b1}});

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    function automatic logic [c_PC_W-1:0] f_popcount(input logic [RES_W-1:0] v);
        logic [c_PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < RES_W; i++) begin
            n = n + c_PC_W'(v[i]);
        end
        return n;
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_drain_cnt;

    logic [KEY_W-1:0] r_key;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_vec_count;
    logic [CNT_W-1:0] r_mismatch;
    logic [CNT_W-1:0] r_bit_err;

    // Pipeline stage registers
    logic             r_s1_valid;
    logic [RES_W-1:0] r_s1_result;
    logic [RES_W-1:0] r_s1_golden;
    logic             r_s2_valid;
    logic             r_s2_mis;
    logic [c_PC_W-1:0] r_s2_pop;

    logic             w_start;
    logic             w_accept;
    logic             w_last;
    logic [CNT_W-1:0] w_vec_inc;
    logic [RES_W-1:0] w_golden;
    logic [RES_W-1:0] w_diff;
    logic [c_ADD_W-1:0] w_bit_sum;
    logic [CNT_W-1:0] w_bit_next;
    logic [CNT_W-1:0] w_mis_next;
    logic             w_busy;
    logic             w_done;

    assign w_start   = (r_state == c_IDLE) && start_i;
    assign w_accept  = (r_state == c_RUN) && valid_i;
    assign w_vec_inc = r_vec_count + CNT_W'(1);
    assign w_last    = w_accept && (w_vec_inc == r_num);
    assign w_golden  = RES_W'(operand1_i) * RES_W'(operand2_i);
    assign w_diff    = r_s1_result ^ r_s1_golden;

    assign w_bit_sum  = c_ADD_W'(r_bit_err) + c_ADD_W'(r_s2_pop);
    assign w_bit_next = (w_bit_sum > c_CNT_MAX) ? {CNT_W{1'b1}} : w_bit_sum[CNT_W-1:0];
    assign w_mis_next = (r_mismatch == {CNT_W{1'b1}}) ? r_mismatch : r_mismatch + CNT_W'(1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    w_state_next = (num_vectors_i == '0) ? c_DONE : c_RUN;
                end
            end
            c_RUN: begin
                if (w_last) begin
                    w_state_next = c_DRAIN;
                end
            end
            c_DRAIN: begin
                // Two cycles lets the last vector clear S2 and land in S3.
                if (r_drain_cnt) begin
                    w_state_next = c_DONE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_RUN, c_DRAIN: w_busy = 1'b1;
            c_DONE:         w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drain_cnt <= 1'b0;
        end else begin
            r_drain_cnt <= (r_state == c_DRAIN) ? ~r_drain_cnt : 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline S1 (register + golden) and S2 (diff, flag, popcount)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_result <= '0;
            r_s1_golden <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_mis    <= 1'b0;
            r_s2_pop    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_result <= result_i;
                r_s1_golden <= w_golden;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mis <= |w_diff;
                r_s2_pop <= f_popcount(w_diff);
            end
        end
    end

    // ------------------------------------------------------------------
    // Window control and S3 accumulation. The pipeline is always empty in
    // IDLE (DRAIN flushes it), so clearing on start never races an update.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_key       <= '0;
            r_num       <= '0;
            r_vec_count <= '0;
            r_mismatch  <= '0;
            r_bit_err   <= '0;
        end else if (w_start) begin
            r_key       <= keyinput_i;
            r_num       <= num_vectors_i;
            r_vec_count <= '0;
            r_mismatch  <= '0;
            r_bit_err   <= '0;
        end else begin
            if (w_accept) begin
                r_vec_count <= w_vec_inc;
            end
            if (r_s2_valid) begin
                if (r_s2_mis) begin
                    r_mismatch <= w_mis_next;
                end
                r_bit_err <= w_bit_next;
            end
        end
    end

    assign busy_o            = w_busy;
    assign done_o            = w_done;
    assign key_o             = r_key;
    assign vec_count_o       = r_vec_count;
    assign mismatch_count_o  = r_mismatch;
    assign bit_error_total_o = r_bit_err;

`ifdef LMEM_FIRST_FAIL_EN
    // Operands and window index ride alongside the checked data so the
    // capture in S3 sees the vector that produced the mismatch flag.
    logic [OP_W-1:0]  r_s1_op1;
    logic [OP_W-1:0]  r_s1_op2;
    logic [CNT_W-1:0] r_s1_idx;
    logic [OP_W-1:0]  r_s2_op1;
    logic [OP_W-1:0]  r_s2_op2;
    logic [RES_W-1:0] r_s2_result;
    logic [CNT_W-1:0] r_s2_idx;
    logic             r_ff_valid;
    logic [CNT_W-1:0] r_ff_idx;
    logic [OP_W-1:0]  r_ff_op1;
    logic [OP_W-1:0]  r_ff_op2;
    logic [RES_W-1:0] r_ff_result;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_op1    <= '0;
            r_s1_op2    <= '0;
            r_s1_idx    <= '0;
            r_s2_op1    <= '0;
            r_s2_op2    <= '0;
            r_s2_result <= '0;
            r_s2_idx    <= '0;
            r_ff_valid  <= 1'b0;
            r_ff_idx    <= '0;
            r_ff_op1    <= '0;
            r_ff_op2    <= '0;
            r_ff_result <= '0;
        end else begin
            if (w_accept) begin
                r_s1_op1 <= operand1_i;
                r_s1_op2 <= operand2_i;
                r_s1_idx <= r_vec_count;
            end
            if (r_s1_valid) begin
                r_s2_op1    <= r_s1_op1;
                r_s2_op2    <= r_s1_op2;
                r_s2_result <= r_s1_result;
                r_s2_idx    <= r_s1_idx;
            end
            if (w_start) begin
                r_ff_valid  <= 1'b0;
                r_ff_idx    <= '0;
                r_ff_op1    <= '0;
                r_ff_op2    <= '0;
                r_ff_result <= '0;
            end else if (r_s2_valid && r_s2_mis && !r_ff_valid) begin
                r_ff_valid  <= 1'b1;
                r_ff_idx    <= r_s2_idx;
                r_ff_op1    <= r_s2_op1;
                r_ff_op2    <= r_s2_op2;
                r_ff_result <= r_s2_result;
            end
        end
    end

    assign first_fail_valid_o  = r_ff_valid;
    assign first_fail_idx_o    = r_ff_idx;
    assign first_fail_op1_o    = r_ff_op1;
    assign first_fail_op2_o    = r_ff_op2;
    assign first_fail_result_o = r_ff_result;
`endif

endmodule
`default_nettype wire

// File: tb/tb_locked_mult_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_locked_mult_error_monitor
// Purpose  : Self-checking bench for locked_mult_error_monitor. Instance A
//            uses default widths; instance B uses 4-bit counters to exercise
//            saturation. Expected results come from a vector-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_locked_mult_error_monitor;

    typedef struct packed {
        logic        v;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic [31:0] num_a;
    logic [3:0]  num_b;
    logic [31:0] key;
    logic        valid;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [15:0] res;

    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] key_a, vec_a, mis_a, bit_a, key_b;
    logic [3:0]  vec_b, mis_b, bit_b;

`ifdef LMEM_FIRST_FAIL_EN
    logic        ffv_a, ffv_b;
    logic [31:0] ffi_a;
    logic [3:0]  ffi_b;
    logic [7:0]  ffa_a, ffb_a, ffa_b, ffb_b;
    logic [15:0] ffr_a, ffr_b;
`endif

    int   n_checks;
    int   n_errors;
    bit   sel;
    vec_t stim[$];

    logic        busy_s, done_s;
    logic [31:0] key_s, vec_s, mis_s, bit_s;

    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign key_s  = sel ? key_b : key_a;
    assign vec_s  = sel ? {28'd0, vec_b} : vec_a;
    assign mis_s  = sel ? {28'd0, mis_b} : mis_a;
    assign bit_s  = sel ? {28'd0, bit_b} : bit_a;

    locked_mult_error_monitor u_dut_a (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start_a),
        .num_vectors_i     (num_a),
        .keyinput_i        (key),
        .valid_i           (valid),
        .operand1_i        (op1),
        .operand2_i        (op2),
        .result_i          (res),
        .busy_o            (busy_a),
        .done_o            (done_a),
        .key_o             (key_a),
        .vec_count_o       (vec_a),
        .mismatch_count_o  (mis_a),
        .bit_error_total_o (bit_a)
`ifdef LMEM_FIRST_FAIL_EN
        ,
        .first_fail_valid_o  (ffv_a),
        .first_fail_idx_o    (ffi_a),
        .first_fail_op1_o    (ffa_a),
        .first_fail_op2_o    (ffb_a),
        .first_fail_result_o (ffr_a)
`endif
    );

    locked_mult_error_monitor #(.CNT_W(4)) u_dut_b (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start_b),
        .num_vectors_i     (num_b),
        .keyinput_i        (key),
        .valid_i           (valid),
        .operand1_i        (op1),
        .operand2_i        (op2),
        .result_i          (res),
        .busy_o            (busy_b),
        .done_o            (done_b),
        .key_o             (key_b),
        .vec_count_o       (vec_b),
        .mismatch_count_o  (mis_b),
        .bit_error_total_o (bit_b)
`ifdef LMEM_FIRST_FAIL_EN
        ,
        .first_fail_valid_o  (ffv_b),
        .first_fail_idx_o    (ffi_b),
        .first_fail_op1_o    (ffa_b),
        .first_fail_op2_o    (ffb_b),
        .first_fail_result_o (ffr_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
        vec_t e;
        e.v = v; e.a = a; e.b = b; e.r = r;
        stim.push_back(e);
    endtask

    // Runs one window over the vectors in stim and checks it against the
    // model: only the first num valid entries count, valids after are dropped.
    task automatic run_window(input bit use_b, input logic [31:0] num,
                              input logic [31:0] k, input string tag);
        longint      mis, bits, maxv, g;
        int          acc, last, dones, done_cyc, exp_done;
        logic [31:0] d_vec, d_mis, d_bit;
        logic        d_busy;
        logic        ff_seen;
        longint      ff_idx;
        vec_t        ff_v;

        maxv = use_b ? 64'd15 : 64'hFFFF_FFFF;
        mis = 0; bits = 0; acc = 0; last = -1;
        ff_seen = 1'b0; ff_idx = 0; ff_v = '0;
        foreach (stim[i]) begin
            if (stim[i].v && acc < int'(num)) begin
                g = longint'(stim[i].a) * longint'(stim[i].b);
                if (longint'(stim[i].r) != g) begin
                    mis++;
                    if (!ff_seen) begin
                        ff_seen = 1'b1; ff_idx = acc; ff_v = stim[i];
                    end
                end
                bits += $countones(stim[i].r ^ g[15:0]);
                acc++;
                last = i;
            end
        end
        if (mis > maxv) mis = maxv;
        if (bits > maxv) bits = maxv;
        exp_done = (num == 0) ? 1 : last + 4;

        sel = use_b;
        @(negedge clk);
        if (use_b) begin start_b = 1'b1; num_b = num[3:0]; end
        else begin start_a = 1'b1; num_a = num; end
        key = k;
        // A valid on the start cycle must be ignored.
        valid = 1'b1; op1 = 8'($urandom); op2 = 8'($urandom); res = 16'($urandom);

        dones = 0; done_cyc = -1;
        d_vec = 'x; d_mis = 'x; d_bit = 'x; d_busy = 1'bx;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
            if (c == 1 && num != 0) chk({tag, "_busy_run"}, busy_s, 1);
            if (done_s) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = c; d_vec = vec_s; d_mis = mis_s; d_bit = bit_s; d_busy = busy_s;
                end
            end
            if (c - 1 < stim.size()) begin
                valid = stim[c-1].v; op1 = stim[c-1].a; op2 = stim[c-1].b; res = stim[c-1].r;
            end else begin
                valid = 1'b0;
            end
            if (c > stim.size() && done_cyc >= 0 && c >= done_cyc + 2) break;
        end

        chk({tag, "_done_count"}, dones, 1);
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_busy_at_done"}, d_busy, 0);
        chk({tag, "_vec"}, d_vec, acc);
        chk({tag, "_mis"}, d_mis, mis);
        chk({tag, "_bits"}, d_bit, bits);
        // Results and key hold in IDLE, even with stray valids present.
        valid = 1'b1; op1 = 8'h01; op2 = 8'h01; res = 16'h0;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk({tag, "_hold_vec"}, vec_s, acc);
        chk({tag, "_hold_mis"}, mis_s, mis);
        chk({tag, "_hold_bits"}, bit_s, bits);
        chk({tag, "_key"}, key_s, k);
        chk({tag, "_idle_busy"}, busy_s, 0);
`ifdef LMEM_FIRST_FAIL_EN
        if (!use_b) begin
            chk({tag, "_ff_valid"}, ffv_a, ff_seen);
            if (ff_seen) begin
                chk({tag, "_ff_idx"}, ffi_a, ff_idx);
                chk({tag, "_ff_op1"}, ffa_a, ff_v.a);
                chk({tag, "_ff_op2"}, ffb_a, ff_v.b);
                chk({tag, "_ff_res"}, ffr_a, ff_v.r);
            end
        end
`endif
        stim.delete();
    endtask

    initial begin
        logic [15:0] g16;
        int          n, nv;
        n_checks = 0; n_errors = 0; sel = 1'b0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; num_a = '0; num_b = '0;
        key = '0; valid = 1'b0; op1 = '0; op2 = '0; res = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_key", key_a, 0);
        chk("reset_vec", vec_a, 0);
        chk("reset_mis", mis_a, 0);
        chk("reset_bits", bit_a, 0);

        // Correct key: every result matches.
        add(1, 8'h03, 8'h05, 16'h000F); add(1, 8'hFF, 8'hFF, 16'hFE01);
        add(1, 8'h00, 8'h7A, 16'h0000); add(1, 8'h10, 8'h10, 16'h0100);
        run_window(0, 4, 32'hB6A1E72D, "correct");

        // Corrupted outputs: 1 + 2 flipped bits.
        add(1, 8'h0F, 8'h10, 16'h00F1); add(1, 8'h02, 8'h02, 16'h0007);
        add(1, 8'h01, 8'h01, 16'h0001);
        run_window(0, 3, 32'h1234_5678, "corrupt");

        // Window boundary with a mid-window gap and trailing valids.
        add(1, 8'h05, 8'h06, 16'h001F); add(0, 8'h77, 8'h77, 16'hFFFF);
        add(1, 8'h09, 8'h09, 16'h0051); add(1, 8'hAA, 8'h02, 16'h0000);
        add(1, 8'h33, 8'h03, 16'h1234); add(1, 8'h44, 8'h44, 16'hBEEF);
        add(1, 8'h12, 8'h34, 16'h0000);
        run_window(0, 2, 32'hCAFE_0001, "boundary");

        // Zero-length window.
        run_window(0, 0, 32'h0BAD_F00D, "zero");

        // Saturation on the 4-bit-counter instance: 16 flips per vector.
        for (int i = 0; i < 5; i++) begin
            op1 = 8'($urandom); op2 = 8'($urandom);
            g16 = 16'(op1) * 16'(op2);
            add(1, op1, op2, g16 ^ 16'hFFFF);
        end
        run_window(1, 5, 32'h5A5A_5A5A, "saturate");

        // Reset mid-RUN after 2 of 5 vectors.
        sel = 1'b0;
        @(negedge clk);
        start_a = 1'b1; num_a = 5; key = 32'hDEAD_BEEF;
        @(negedge clk);
        start_a = 1'b0; valid = 1'b1; op1 = 8'h03; op2 = 8'h03; res = 16'h0000;
        @(negedge clk);
        op1 = 8'h02; op2 = 8'h02; res = 16'h0004;
        @(negedge clk);
        valid = 1'b0;
        chk("rstmid_vec_before", vec_a, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_busy", busy_a, 0);
        chk("rstmid_key", key_a, 0);
        chk("rstmid_vec", vec_a, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rstmid_no_done", done_a, 0);
            chk("rstmid_mis", mis_a, 0);
            chk("rstmid_bits", bit_a, 0);
        end
        add(1, 8'h07, 8'h08, 16'h0038); add(1, 8'h07, 8'h08, 16'h0039);
        run_window(0, 2, 32'h0000_0042, "after_rst");

        // Randomized windows with gaps and random corruption.
        for (int w = 0; w < 10; w++) begin
            n = $urandom_range(1, 8);
            nv = 0;
            while (nv < n) begin
                op1 = 8'($urandom); op2 = 8'($urandom);
                g16 = 16'(op1) * 16'(op2);
                if ($urandom_range(0, 1) == 1) g16 = g16 ^ 16'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    add(1, op1, op2, g16); nv++;
                end else begin
                    add(0, op1, op2, g16);
                end
            end
            for (int x = 0; x < int'($urandom_range(0, 3)); x++) begin
                add(1'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
            end
            run_window(w[0], 32'(n), $urandom, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
